k12a_stack_seq: RTL and testbench

K12A_STACK_SEQ -- requirements
Module: k12a_stack_seq

---
 rtl/k12a_stack_seq_pkg.sv | 35 +++
 rtl/k12a_stack_seq.sv | 218 +++++++++++++++++++++
 tb/tb_k12a_stack_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/k12a_stack_seq_pkg.sv
// -----------------------------------------------------------------------------
// k12a_stack_seq_pkg
// Shared definitions for the K12A stack sequencer:
//   op_kind_e  - stack operation encoding on op_kind (PUSH/POP/CALL/RET)
//   state_e    - sequencer step states
//   FAULT_OVF  - fault vector bit index for stack overflow
//   FAULT_UDF  - fault vector bit index for stack underflow
//   is_push_kind() - true for operations that grow the stack
// -----------------------------------------------------------------------------
package k12a_stack_seq_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEC   = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_INC   = 3'd4
  } state_e;

  localparam int FAULT_OVF = 0;
  localparam int FAULT_UDF = 1;

  // PUSH and CALL move SP downward; POP and RET move it upward.
  function automatic logic is_push_kind(input op_kind_e kind);
    return (kind == OP_PUSH) || (kind == OP_CALL);
  endfunction

endpackage

// File: rtl/k12a_stack_seq.sv
// -----------------------------------------------------------------------------
// k12a_stack_seq
// Control sequencer for the K12A hardware stack. It steps the SP register,
// the address inc/dec unit and the memory strobes through PUSH/POP (one byte)
// and CALL/RET (two PC bytes). The stack grows downward with pre-decrement.
//
// Ports:
//   cpu_clock     in   sole clock, rising edge
//   reset         in   asynchronous, active-high reset
//   op_valid      in   stack operation request
//   op_kind[1:0]  in   PUSH=0, POP=1, CALL=2, RET=3
//   op_ready      out  request can be accepted (IDLE only)
//   sp[15:0]      in   current stack pointer register value
//   sp_load       out  SP drives addr_bus
//   sp_store      out  SP latches addr_bus on the next edge
//   incdec_drive  out  inc/dec unit drives addr_bus with sp+1 / sp-1
//   incdec_dir    out  0 = sp-1, 1 = sp+1
//   mem_read      out  memory read at addr_bus
//   mem_write     out  memory write at addr_bus
//   byte_sel      out  0 = low/single byte, 1 = PC high byte
//   op_done       out  pulse on the last step of an operation
//   fault[1:0]    out  sticky flags: bit0 overflow, bit1 underflow
//   fault_clr     in   clears both fault bits (a simultaneous new fault wins)
// -----------------------------------------------------------------------------
module k12a_stack_seq
  import k12a_stack_seq_pkg::*;
#(
  parameter logic [15:0] STACK_EMPTY = 16'h0000,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_kind,
  output logic        op_ready,
  input  logic [15:0] sp,
  output logic        sp_load,
  output logic        sp_store,
  output logic        incdec_drive,
  output logic        incdec_dir,
  output logic        mem_read,
  output logic        mem_write,
  output logic        byte_sel,
  output logic        op_done,
  output logic [1:0]  fault,
  input  logic        fault_clr
);

  // Popping the first RET byte at this SP leaves SP at STACK_EMPTY, so the
  // second byte would underflow.
  localparam logic [15:0] RET_LAST_SP = STACK_EMPTY - 16'h0001;

  state_e     state_r;
  state_e     state_nxt_s;
  op_kind_e   kind_r;
  op_kind_e   kind_nxt_s;
  op_kind_e   req_kind_s;
  logic       byte_cnt_r;
  logic       byte_cnt_nxt_s;
  logic [1:0] fault_r;
  logic [1:0] fault_set_s;
  logic       fault_done_r;
  logic       fault_done_nxt_s;
  logic       first_of_pair_s;
  logic       ovf_next_s;
  logic       udf_next_s;

  assign req_kind_s = op_kind_e'(op_kind);
  assign fault      = fault_r;

  // First byte of a two-byte CALL/RET; the per-byte limit check applies here.
  assign first_of_pair_s = ((kind_r == OP_CALL) || (kind_r == OP_RET)) && !byte_cnt_r;
  // In WRITE the SP already holds the decremented address of the first byte.
  assign ovf_next_s      = (sp == STACK_LIMIT);
  // In INC the SP still holds the address of the byte just read.
  assign udf_next_s      = (sp == RET_LAST_SP);

  // State register, latched operation, byte counter and sticky fault flags.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      kind_r       <= OP_PUSH;
      byte_cnt_r   <= 1'b0;
      fault_r      <= 2'b00;
      fault_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      kind_r       <= kind_nxt_s;
      byte_cnt_r   <= byte_cnt_nxt_s;
      fault_done_r <= fault_done_nxt_s;
      // Clear first, then OR in new faults so a simultaneous fault survives.
      fault_r      <= (fault_clr ? 2'b00 : fault_r) | fault_set_s;
    end
  end

  // Next-state logic, acceptance-time fault checks and per-byte checks.
  always_comb begin
    state_nxt_s      = state_r;
    kind_nxt_s       = kind_r;
    byte_cnt_nxt_s   = byte_cnt_r;
    fault_set_s      = 2'b00;
    fault_done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (op_valid) begin
          kind_nxt_s     = req_kind_s;
          byte_cnt_nxt_s = 1'b0;
          if (is_push_kind(req_kind_s)) begin
            if (sp == STACK_LIMIT) begin
              fault_set_s[FAULT_OVF] = 1'b1;
              fault_done_nxt_s       = 1'b1;
              state_nxt_s            = ST_IDLE;
            end else begin
              state_nxt_s = ST_DEC;
            end
          end else begin
            if (sp == STACK_EMPTY) begin
              fault_set_s[FAULT_UDF] = 1'b1;
              fault_done_nxt_s       = 1'b1;
              state_nxt_s            = ST_IDLE;
            end else begin
              state_nxt_s = ST_READ;
            end
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DEC: begin
        state_nxt_s = ST_WRITE;
      end
      ST_WRITE: begin
        if (first_of_pair_s) begin
          if (ovf_next_s) begin
            // Abort: the high byte already pushed stays on the stack.
            fault_set_s[FAULT_OVF] = 1'b1;
            state_nxt_s            = ST_IDLE;
          end else begin
            byte_cnt_nxt_s = 1'b1;
            state_nxt_s    = ST_DEC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_nxt_s = ST_INC;
      end
      ST_INC: begin
        if (first_of_pair_s) begin
          if (udf_next_s) begin
            // Abort: the low byte already popped stays consumed.
            fault_set_s[FAULT_UDF] = 1'b1;
            state_nxt_s            = ST_IDLE;
          end else begin
            byte_cnt_nxt_s = 1'b1;
            state_nxt_s    = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Strobe decode from state, byte counter and latched operation.
  always_comb begin
    op_ready     = 1'b0;
    sp_load      = 1'b0;
    sp_store     = 1'b0;
    incdec_drive = 1'b0;
    incdec_dir   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    byte_sel     = 1'b0;
    op_done      = 1'b0;
    case (kind_r)
      OP_CALL: byte_sel = !byte_cnt_r;   // high byte first
      OP_RET:  byte_sel = byte_cnt_r;    // low byte first
      default: byte_sel = 1'b0;
    endcase
    case (state_r)
      ST_IDLE: begin
        op_ready = 1'b1;
        byte_sel = 1'b0;
        op_done  = fault_done_r;         // rejected request completes here
      end
      ST_DEC: begin
        incdec_drive = 1'b1;
        incdec_dir   = 1'b0;
        sp_store     = 1'b1;
      end
      ST_WRITE: begin
        sp_load   = 1'b1;
        mem_write = 1'b1;
        op_done   = !first_of_pair_s || ovf_next_s;
      end
      ST_READ: begin
        sp_load  = 1'b1;
        mem_read = 1'b1;
      end
      ST_INC: begin
        incdec_drive = 1'b1;
        incdec_dir   = 1'b1;
        sp_store     = 1'b1;
        op_done      = !first_of_pair_s || udf_next_s;
      end
      default: begin
        op_ready = 1'b0;
        byte_sel = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_k12a_stack_seq.sv
// -----------------------------------------------------------------------------
// tb_k12a_stack_seq
// Directed bench for k12a_stack_seq. The bench models the SP register and
// inc/dec unit so SP follows the sequencer's strobes.
// Strobe vector layout (8 bits):
//   {sp_load, sp_store, incdec_drive, incdec_dir&drive, mem_read, mem_write,
//    byte_sel, op_done}
//   DEC=60 (+bs 62)  WRITE=84 (+done 85, +bs 86, +bs+done 87)
//   READ=88 (+bs 8A) INC=70 (+done 71, +bs 72, +bs+done 73)  IDLE=00 / 01
// -----------------------------------------------------------------------------
module tb_k12a_stack_seq;

    logic        cpu_clock;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_kind;
    logic        op_ready;
    logic [15:0] sp = 16'h0000;
    logic        sp_load;
    logic        sp_store;
    logic        incdec_drive;
    logic        incdec_dir;
    logic        mem_read;
    logic        mem_write;
    logic        byte_sel;
    logic        op_done;
    logic [1:0]  fault;
    logic        fault_clr;

    logic        sp_wr_en;
    logic [15:0] sp_wr_val;
    logic        rand_on;
    logic [7:0]  strobes;
    int          n_cmp = 0;
    int          n_err = 0;

    k12a_stack_seq #(
        .STACK_EMPTY (16'h0000),
        .STACK_LIMIT (16'hFF00)
    ) dut (
        .cpu_clock    (cpu_clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_kind      (op_kind),
        .op_ready     (op_ready),
        .sp           (sp),
        .sp_load      (sp_load),
        .sp_store     (sp_store),
        .incdec_drive (incdec_drive),
        .incdec_dir   (incdec_dir),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .byte_sel     (byte_sel),
        .op_done      (op_done),
        .fault        (fault),
        .fault_clr    (fault_clr)
    );

    assign strobes = {sp_load, sp_store, incdec_drive, incdec_dir & incdec_drive,
                      mem_read, mem_write, byte_sel, op_done};

    // Compare one observed value against its expectation and count the result.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Free-running clock.
    initial begin
        cpu_clock = 1'b0;
        forever #5 cpu_clock = ~cpu_clock;
    end

    // SP register plus inc/dec unit as the datapath would behave.
    always @(posedge cpu_clock) begin
        if (sp_wr_en) sp <= sp_wr_val;
        else if (sp_store && incdec_drive) sp <= incdec_dir ? sp + 16'd1 : sp - 16'd1;
    end

    // Single bus driver and read/write exclusivity during random traffic.
    always @(negedge cpu_clock) begin
        if (rand_on) begin
            check("bus_driver_conflict", {31'd0, sp_load & incdec_drive}, 32'd0);
            check("read_write_conflict", {31'd0, mem_read & mem_write}, 32'd0);
        end
    end

    // Check one step cycle: strobes, op_ready, fault; ends at posedge+1.
    task automatic cyc(input string tag, input logic [7:0] s, input logic r, input logic [1:0] f);
        @(negedge cpu_clock);
        check(tag, {21'd0, strobes, op_ready, fault}, {21'd0, s, r, f});
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] kind);
        op_valid = 1'b1;
        op_kind  = kind;
        @(posedge cpu_clock);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic set_sp(input logic [15:0] v);
        sp_wr_val = v;
        sp_wr_en  = 1'b1;
        @(posedge cpu_clock);
        #1;
        sp_wr_en  = 1'b0;
    endtask

    task automatic clear_faults();
        fault_clr = 1'b1;
        @(posedge cpu_clock);
        #1;
        fault_clr = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        reset = 1'b1; op_valid = 1'b0; op_kind = 2'd0; fault_clr = 1'b0;
        sp_wr_en = 1'b0; sp_wr_val = 16'h0000; rand_on = 1'b0;

        // Reset state
        @(negedge cpu_clock);
        check("reset_outputs", {22'd0, strobes, fault}, {22'd0, 8'h00, 2'b00});
        @(posedge cpu_clock); #1;
        reset = 1'b0;
        cyc("idle_after_reset", 8'h00, 1'b1, 2'b00);

        // PUSH at 0000
        set_sp(16'h0000);
        issue(2'd0);
        cyc("push_dec", 8'h60, 1'b0, 2'b00);
        cyc("push_write", 8'h85, 1'b0, 2'b00);
        cyc("push_idle", 8'h00, 1'b1, 2'b00);
        check("push_sp", {16'd0, sp}, {16'd0, 16'hFFFF});

        // POP at FFFF
        issue(2'd1);
        cyc("pop_read", 8'h88, 1'b0, 2'b00);
        cyc("pop_inc", 8'h71, 1'b0, 2'b00);
        cyc("pop_idle", 8'h00, 1'b1, 2'b00);
        check("pop_sp", {16'd0, sp}, {16'd0, 16'h0000});

        // CALL at 0000: high byte then low byte
        issue(2'd2);
        cyc("call_dec_hi", 8'h62, 1'b0, 2'b00);
        cyc("call_write_hi", 8'h86, 1'b0, 2'b00);
        cyc("call_dec_lo", 8'h60, 1'b0, 2'b00);
        cyc("call_write_lo", 8'h85, 1'b0, 2'b00);
        cyc("call_idle", 8'h00, 1'b1, 2'b00);
        check("call_sp", {16'd0, sp}, {16'd0, 16'hFFFE});

        // RET at FFFE: low byte then high byte
        issue(2'd3);
        cyc("ret_read_lo", 8'h88, 1'b0, 2'b00);
        cyc("ret_inc_lo", 8'h70, 1'b0, 2'b00);
        cyc("ret_read_hi", 8'h8A, 1'b0, 2'b00);
        cyc("ret_inc_hi", 8'h73, 1'b0, 2'b00);
        cyc("ret_idle", 8'h00, 1'b1, 2'b00);
        check("ret_sp", {16'd0, sp}, {16'd0, 16'h0000});

        // POP at STACK_EMPTY: underflow, single op_done, then clear
        issue(2'd1);
        cyc("pop_empty_done", 8'h01, 1'b1, 2'b10);
        cyc("pop_empty_after", 8'h00, 1'b1, 2'b10);
        clear_faults();
        check("fault_clr", {30'd0, fault}, {30'd0, 2'b00});

        // PUSH at STACK_LIMIT: overflow, SP untouched
        set_sp(16'hFF00);
        issue(2'd0);
        cyc("push_limit_done", 8'h01, 1'b1, 2'b01);
        check("push_limit_sp", {16'd0, sp}, {16'd0, 16'hFF00});
        clear_faults();

        // CALL at FF01: first byte lands, abort before second DEC
        set_sp(16'hFF01);
        issue(2'd2);
        cyc("call_ovf_dec", 8'h62, 1'b0, 2'b00);
        cyc("call_ovf_write", 8'h87, 1'b0, 2'b00);
        cyc("call_ovf_idle", 8'h00, 1'b1, 2'b01);
        check("call_ovf_sp", {16'd0, sp}, {16'd0, 16'hFF00});
        clear_faults();

        // RET at FFFF: first byte pops, abort before second READ
        set_sp(16'hFFFF);
        issue(2'd3);
        cyc("ret_udf_read", 8'h88, 1'b0, 2'b00);
        cyc("ret_udf_inc", 8'h71, 1'b0, 2'b00);
        cyc("ret_udf_idle", 8'h00, 1'b1, 2'b10);
        check("ret_udf_sp", {16'd0, sp}, {16'd0, 16'h0000});

        // fault_clr in the same cycle as a new overflow: overflow survives
        set_sp(16'hFF00);
        fault_clr = 1'b1;
        issue(2'd0);
        fault_clr = 1'b0;
        cyc("clr_vs_new_fault", 8'h01, 1'b1, 2'b01);

        // Reset during WRITE of a CALL
        set_sp(16'h0000);
        issue(2'd2);
        cyc("call_rst_dec", 8'h62, 1'b0, 2'b01);
        reset = 1'b1;
        #1;
        check("reset_mid_call", {22'd0, strobes, fault}, {22'd0, 8'h00, 2'b00});
        @(posedge cpu_clock); @(posedge cpu_clock); #1;
        reset = 1'b0;
        cyc("after_mid_reset", 8'h00, 1'b1, 2'b00);
        check("mid_reset_sp", {16'd0, sp}, {16'd0, 16'hFFFF});

        // Random back-to-back traffic with op_valid held high
        set_sp(16'h8000);
        rand_on  = 1'b1;
        op_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op_kind = 2'($urandom_range(3, 0));
            @(posedge cpu_clock); #1;
        end
        op_valid = 1'b0;
        repeat (5) @(posedge cpu_clock);
        #1;
        rand_on = 1'b0;
        check("random_drain_ready", {31'd0, op_ready}, {31'd0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
